// File: rtl/alu_ctrl_stage_if.sv
// ID/EX handshake and payload bundle for alu_ctrl_stage.
// The slave modport is the stage; the master modport is the surrounding pipeline.
interface alu_ctrl_stage_if #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 3
);
    logic              in_valid;
    logic              in_ready;
    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic              funct7_5;
    logic [XLEN-1:0]   op_a_in;
    logic [XLEN-1:0]   op_b_in;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] ALU_Ctrl;
    logic [3:0]        sub_op;
    logic [XLEN-1:0]   op_a;
    logic [XLEN-1:0]   op_b;
    logic              illegal;

    modport slave (
        input  in_valid, opcode, funct3, funct7_5, op_a_in, op_b_in, out_ready,
        output in_ready, out_valid, ALU_Ctrl, sub_op, op_a, op_b, illegal
    );

    modport master (
        output in_valid, opcode, funct3, funct7_5, op_a_in, op_b_in, out_ready,
        input  in_ready, out_valid, ALU_Ctrl, sub_op, op_a, op_b, illegal
    );
endinterface

// File: rtl/alu_ctrl_stage.sv
// RV32I ALU-control decode with a valid/ready register at the ID/EX boundary.
// Define ALU_STAGE_SKID_EN for a 2-entry (main + skid) buffer with a registered in_ready.
module alu_ctrl_stage #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 3
) (
    input  logic CLK,
    input  logic rst,
    input  logic flush,
    alu_ctrl_stage_if.slave bus
);
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [CTRL_W-1:0] C_ADD  = CTRL_W'(0);
    localparam logic [CTRL_W-1:0] C_SLT  = CTRL_W'(1);
    localparam logic [CTRL_W-1:0] C_LOG  = CTRL_W'(2);
    localparam logic [CTRL_W-1:0] C_SHF  = CTRL_W'(3);
    localparam logic [CTRL_W-1:0] C_BR   = CTRL_W'(4);
    localparam logic [CTRL_W-1:0] C_NONE = CTRL_W'(7);

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [3:0]        sub;
        logic [XLEN-1:0]   a;
        logic [XLEN-1:0]   b;
        logic              ill;
    } entry_t;

    localparam entry_t IDLE_E = '{ctrl: C_NONE, sub: 4'b0000, a: '0, b: '0, ill: 1'b0};

    entry_t dec;
    logic   alt;
    logic   f3_alt_ok;

    // Only ADD/SUB and SRL/SRA accept funct7[5] on register-register ops.
    assign f3_alt_ok = (bus.funct3 == 3'b000) || (bus.funct3 == 3'b101);

    always_comb begin
        dec      = '{ctrl: C_NONE, sub: 4'b0000, a: bus.op_a_in, b: bus.op_b_in, ill: 1'b1};
        alt      = 1'b0;
        case (bus.opcode)
            OPC_OP, OPC_OPIMM: begin
                if (bus.opcode == OPC_OP) alt = bus.funct7_5 && f3_alt_ok;
                else                      alt = bus.funct7_5 && (bus.funct3 == 3'b101);
                if (!(bus.opcode == OPC_OP && bus.funct7_5 && !f3_alt_ok)) begin
                    dec.ill = 1'b0;
                    dec.sub = {alt, bus.funct3};
                    case (bus.funct3)
                        3'b000:         dec.ctrl = C_ADD;
                        3'b010, 3'b011: dec.ctrl = C_SLT;
                        3'b001, 3'b101: dec.ctrl = C_SHF;
                        default:        dec.ctrl = C_LOG;
                    endcase
                end
            end
            OPC_LOAD, OPC_STORE, OPC_JALR, OPC_JAL, OPC_LUI, OPC_AUIPC: begin
                dec.ill  = 1'b0;
                dec.ctrl = C_ADD;
            end
            OPC_BRANCH: begin
                if (bus.funct3 != 3'b010 && bus.funct3 != 3'b011) begin
                    dec.ill  = 1'b0;
                    dec.ctrl = C_BR;
                    dec.sub  = {1'b0, bus.funct3};
                end
            end
            default: ;
        endcase
    end

    entry_t main_q, main_d;
    logic   main_v_q, main_v_d;
    logic   accept, transfer;

    assign accept   = bus.in_valid && bus.in_ready && !flush;
    assign transfer = main_v_q && bus.out_ready;

`ifdef ALU_STAGE_SKID_EN
    entry_t skid_q, skid_d;
    logic   skid_v_q, skid_v_d;

    // Registered ready: no combinational path from out_ready.
    assign bus.in_ready = !skid_v_q;

    always_comb begin
        main_d   = main_q;
        main_v_d = main_v_q;
        skid_d   = skid_q;
        skid_v_d = skid_v_q;
        if (flush) begin
            main_d   = IDLE_E;
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
        end else if (transfer) begin
            if (skid_v_q) begin
                main_d   = skid_q;
                skid_v_d = 1'b0;
            end else if (accept) begin
                main_d   = dec;
            end else begin
                main_v_d = 1'b0;
            end
        end else if (!main_v_q) begin
            if (accept) begin
                main_d   = dec;
                main_v_d = 1'b1;
            end
        end else if (accept) begin
            skid_d   = dec;
            skid_v_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            main_q   <= IDLE_E;
            main_v_q <= 1'b0;
            skid_q   <= IDLE_E;
            skid_v_q <= 1'b0;
        end else begin
            main_q   <= main_d;
            main_v_q <= main_v_d;
            skid_q   <= skid_d;
            skid_v_q <= skid_v_d;
        end
    end
`else
    assign bus.in_ready = !main_v_q || bus.out_ready;

    always_comb begin
        main_d   = main_q;
        main_v_d = main_v_q;
        if (flush) begin
            main_d   = IDLE_E;
            main_v_d = 1'b0;
        end else if (accept) begin
            main_d   = dec;
            main_v_d = 1'b1;
        end else if (transfer) begin
            main_v_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            main_q   <= IDLE_E;
            main_v_q <= 1'b0;
        end else begin
            main_q   <= main_d;
            main_v_q <= main_v_d;
        end
    end
`endif

    assign bus.out_valid = main_v_q;
    assign bus.ALU_Ctrl  = main_q.ctrl;
    assign bus.sub_op    = main_q.sub;
    assign bus.op_a      = main_q.a;
    assign bus.op_b      = main_q.b;
    assign bus.illegal   = main_q.ill;
endmodule

// File: tb/tb_alu_ctrl_stage.sv
// Self-checking bench for alu_ctrl_stage: directed steps then random traffic against a queue model.
module tb_alu_ctrl_stage;
    localparam int XLEN = 32;

    logic CLK = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    always #5 CLK = ~CLK;

    alu_ctrl_stage_if #(.XLEN(XLEN), .CTRL_W(3)) bus ();
    alu_ctrl_stage #(.XLEN(XLEN), .CTRL_W(3)) dut (.CLK(CLK), .rst(rst), .flush(flush), .bus(bus));

    typedef struct {
        logic [2:0]  ctrl;
        logic [3:0]  sub;
        logic [31:0] a;
        logic [31:0] b;
        logic        ill;
    } ent_t;

    ent_t q[$];
    int   total = 0;
    int   bad = 0;
    bit   exp_idle_ctrl = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: ALU class and sub-op straight from the RV32I encoding rules.
    function automatic ent_t ref_dec(input logic [6:0] opc, input logic [2:0] f3, input bit f7,
                                     input logic [31:0] a, input logic [31:0] b);
        ent_t e;
        int   cls;
        bit   alt;
        e.a = a; e.b = b; e.ctrl = 3'd7; e.sub = 4'd0; e.ill = 1'b1;
        if (opc == 7'h33 || opc == 7'h13) begin
            if (f3 == 0)                  cls = 0;
            else if (f3 == 2 || f3 == 3)  cls = 1;
            else if (f3 == 1 || f3 == 5)  cls = 3;
            else                          cls = 2;
            if (opc == 7'h33) alt = f7 && (f3 == 0 || f3 == 5);
            else              alt = f7 && (f3 == 5);
            if (!(opc == 7'h33 && f7 && f3 != 0 && f3 != 5)) begin
                e.ill = 1'b0; e.ctrl = 3'(cls); e.sub = 4'(int'(alt) * 8 + int'(f3));
            end
        end else if (opc == 7'h03 || opc == 7'h23 || opc == 7'h67 || opc == 7'h6f ||
                     opc == 7'h37 || opc == 7'h17) begin
            e.ill = 1'b0; e.ctrl = 3'd0;
        end else if (opc == 7'h63) begin
            if (f3 != 2 && f3 != 3) begin
                e.ill = 1'b0; e.ctrl = 3'd4; e.sub = 4'(f3);
            end
        end
        return e;
    endfunction

    task automatic step(input bit iv, input logic [6:0] opc, input logic [2:0] f3, input bit f7,
                        input logic [31:0] a, input logic [31:0] b, input bit ordy, input bit fl);
        bit rdy;
        @(negedge CLK);
        bus.in_valid = iv; bus.opcode = opc; bus.funct3 = f3; bus.funct7_5 = f7;
        bus.op_a_in = a; bus.op_b_in = b; bus.out_ready = ordy; flush = fl;
        #1;
        chk("out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
        if (q.size() > 0) begin
            chk("alu_ctrl", 32'(bus.ALU_Ctrl), 32'(q[0].ctrl));
            chk("sub_op",   32'(bus.sub_op),   32'(q[0].sub));
            chk("op_a",     bus.op_a,          q[0].a);
            chk("op_b",     bus.op_b,          q[0].b);
            chk("illegal",  32'(bus.illegal),  32'(q[0].ill));
        end else if (exp_idle_ctrl) begin
            chk("idle_ctrl", 32'(bus.ALU_Ctrl), 32'h7);
        end
`ifdef ALU_STAGE_SKID_EN
        rdy = (q.size() < 2);
`else
        rdy = (q.size() == 0) || ordy;
`endif
        chk("in_ready", 32'(bus.in_ready), 32'(rdy));
        exp_idle_ctrl = fl;
        if (fl) begin
            q.delete();
        end else begin
            if (q.size() > 0 && ordy) void'(q.pop_front());
            if (iv && rdy) q.push_back(ref_dec(opc, f3, f7, a, b));
        end
    endtask

    logic [6:0] opcs [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h67, 7'h6f, 7'h37, 7'h17, 7'h63, 7'h7f};

    initial begin
        int         idx;
        logic [6:0] ropc;
        bus.in_valid = 1'b0; bus.opcode = 7'h0; bus.funct3 = 3'h0; bus.funct7_5 = 1'b0;
        bus.op_a_in = '0; bus.op_b_in = '0; bus.out_ready = 1'b0;

        repeat (2) @(posedge CLK);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_alu_ctrl",  32'(bus.ALU_Ctrl),  32'h7);
        chk("rst_illegal",   32'(bus.illegal),   32'h0);
        chk("rst_sub_op",    32'(bus.sub_op),    32'h0);
        chk("rst_op_a",      bus.op_a,           32'h0);
        @(negedge CLK);
        rst = 1'b0;
        exp_idle_ctrl = 1'b1;
        @(posedge CLK);
        #1;
        chk("rel_in_ready", 32'(bus.in_ready), 32'h1);

        // SUB, then observe the registered result
        step(1, 7'h33, 3'd0, 1, 32'd10, 32'd3, 1, 0);
        step(0, 7'h00, 3'd0, 0, 32'd0, 32'd0, 1, 0);
        chk("sub_ctrl", 32'(bus.ALU_Ctrl), 32'h0);
        chk("sub_subop", 32'(bus.sub_op), 32'h8);
        chk("sub_a", bus.op_a, 32'd10);
        chk("sub_b", bus.op_b, 32'd3);

        step(1, 7'h63, 3'd1, 0, 32'h11, 32'h22, 1, 0);
        step(1, 7'h13, 3'd5, 1, 32'h33, 32'h44, 1, 0);
        chk("bne_ctrl", 32'(bus.ALU_Ctrl), 32'h4);
        chk("bne_subop", 32'(bus.sub_op), 32'h1);
        step(1, 7'h7f, 3'd0, 0, 32'h55, 32'h66, 1, 0);
        chk("srai_ctrl", 32'(bus.ALU_Ctrl), 32'h3);
        chk("srai_subop", 32'(bus.sub_op), 32'hd);
        step(0, 7'h00, 3'd0, 0, 32'd0, 32'd0, 1, 0);
        chk("ill_flag", 32'(bus.illegal), 32'h1);
        chk("ill_ctrl", 32'(bus.ALU_Ctrl), 32'h7);
        chk("ill_valid", 32'(bus.out_valid), 32'h1);
        step(0, 7'h00, 3'd0, 0, 32'd0, 32'd0, 1, 0);

        // back-to-back accepts into a stalled output
        step(1, 7'h33, 3'd0, 0, 32'd1, 32'd1, 0, 0);
        step(1, 7'h33, 3'd4, 0, 32'd2, 32'd2, 0, 0);
        step(1, 7'h13, 3'd2, 0, 32'd3, 32'd3, 0, 0);
        step(0, 7'h00, 3'd0, 0, 32'd0, 32'd0, 1, 0);
        repeat (4) step(0, 7'h00, 3'd0, 0, 32'd0, 32'd0, 1, 0);

        // flush while stalled, with a concurrent input that must be dropped
        step(1, 7'h33, 3'd0, 0, 32'd5, 32'd5, 0, 0);
        step(1, 7'h33, 3'd1, 0, 32'd6, 32'd6, 0, 0);
        step(1, 7'h33, 3'd2, 0, 32'd7, 32'd7, 0, 1);
        step(0, 7'h00, 3'd0, 0, 32'd0, 32'd0, 1, 0);
        chk("flush_valid", 32'(bus.out_valid), 32'h0);
        step(0, 7'h00, 3'd0, 0, 32'd0, 32'd0, 1, 1);

        for (int i = 0; i < 500; i++) begin
            idx = $urandom_range(0, 10);
            ropc = (idx == 10) ? 7'($urandom) : opcs[idx];
            step($urandom_range(0, 9) < 7, ropc, 3'($urandom), 1'($urandom), $urandom, $urandom,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0);
        end
        repeat (3) step(0, 7'h00, 3'd0, 0, 32'd0, 32'd0, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
